// File: rtl/serial_rx_ctrl.sv
// Serial receive frame controller: it synchronises the line, times mid-bit samples from a baud
// counter, assembles LSB-first words and delivers them through a valid/ready holding register.
module serial_rx_ctrl #(
  parameter int DIV      = 16,
  parameter int BIT_SIZE = 8
) (
  input  logic                clk,
  input  logic                i_sclr_n,
  input  logic                i_dat,
  input  logic                i_ready,
  output logic [BIT_SIZE-1:0] o_dat,
  output logic                o_valid,
  output logic                o_busy,
  output logic                o_frame_err,
  output logic                o_overrun
);

  localparam int CNT_W = $clog2(DIV);
  localparam int BC_W  = $clog2(BIT_SIZE) + 1;
  localparam logic [CNT_W-1:0] HALF_TERM = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TERM = CNT_W'(DIV - 1);
  localparam logic [BC_W-1:0]  LAST_BIT  = BC_W'(BIT_SIZE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state, state_nxt;
  logic                sync_p0, sync_p1, s_dat;
  logic [CNT_W-1:0]    baud_cnt;
  logic [BC_W-1:0]     bit_cnt;
  logic [BIT_SIZE-1:0] shift_q;
  logic                tick, shift_en, bit_clr, good_stop, bad_stop;
  logic                vld_p1;

  // Stage p0/p1: two-flop synchroniser; the line idles high, so reset to 1.
  always_ff @(posedge clk or negedge i_sclr_n) begin
    if (!i_sclr_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= i_dat;
      sync_p1 <= sync_p0;
    end
  end

  assign s_dat  = sync_p1;
  assign o_busy = (state != IDLE);

  always_comb begin
    tick      = 1'b0;
    state_nxt = state;
    shift_en  = 1'b0;
    bit_clr   = 1'b0;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    case (state)
      START:      tick = (baud_cnt == HALF_TERM);
      DATA, STOP: tick = (baud_cnt == FULL_TERM);
      default:    tick = 1'b0;
    endcase
    case (state)
      IDLE: if (!s_dat) state_nxt = START;
      START: begin
        if (tick) begin
          if (!s_dat) begin
            state_nxt = DATA;
            bit_clr   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) state_nxt = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          state_nxt = IDLE;
          good_stop = s_dat;
          bad_stop  = !s_dat;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter restarts on every state change and on each tick, and rests at zero in IDLE.
  always_ff @(posedge clk or negedge i_sclr_n) begin
    if (!i_sclr_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || tick || state == IDLE) baud_cnt <= '0;
      else                                             baud_cnt <= baud_cnt + CNT_W'(1);
      if (bit_clr)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + BC_W'(1);
      if (shift_en) shift_q <= {s_dat, shift_q[BIT_SIZE-1:1]};
    end
  end

  // Stage p1: a good stop sample is applied to the holding register one edge later.
  always_ff @(posedge clk or negedge i_sclr_n) begin
    if (!i_sclr_n) begin
      vld_p1      <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      o_valid     <= 1'b0;
      o_dat       <= '0;
    end else begin
      vld_p1      <= good_stop;
      o_frame_err <= bad_stop;
      o_overrun   <= vld_p1 && o_valid && !i_ready;
      if (vld_p1 && (!o_valid || i_ready)) begin
        o_dat   <= shift_q;
        o_valid <= 1'b1;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_rx_ctrl.sv
// Bench for serial_rx_ctrl: directed frame table, hand-written corner sequences and random
// traffic, all checked every cycle against a frame-timing reference model.
module tb_serial_rx_ctrl;

  localparam int DIV      = 8;
  localparam int BIT_SIZE = 8;
  localparam int LAT      = DIV / 2 + (BIT_SIZE + 1) * DIV + 1;  // 77 clk from t0
  localparam int J_LOAD   = 2 + LAT;  // frame tick index whose edge loads the word

  logic       clk = 1'b0;
  logic       i_sclr_n, i_dat, i_ready;
  logic [7:0] o_dat;
  logic       o_valid, o_busy, o_frame_err, o_overrun;

  serial_rx_ctrl #(.DIV(DIV), .BIT_SIZE(BIT_SIZE)) dut (
    .clk(clk), .i_sclr_n(i_sclr_n), .i_dat(i_dat), .i_ready(i_ready),
    .o_dat(o_dat), .o_valid(o_valid), .o_busy(o_busy),
    .o_frame_err(o_frame_err), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int cnt_busy = 0, cnt_fe = 0, cnt_ov = 0, cnt_vcyc = 0;
  int rise_cyc = 0, frame_m = 0;
  bit prev_valid = 1'b0;

  // Reference model state: line history, frame timing and holding register.
  bit         line_q[$];
  bit         m_busy, m_good, m_valid, m_fe, m_ov;
  int         m_t0, m_good_at;
  logic [7:0] m_word, m_dat;

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         rdy_mode;  // 0 low, 1 high, 2 random
    int         rdy_at;    // frame tick with i_ready forced high, -1 for none
    int         gap;       // idle bit periods after the frame
    bit         pop;       // consume one word afterwards
    logic [7:0] exp_dat;
    bit         exp_valid;
    int         exp_fe;
    int         exp_ov;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    line_q = '{1'b1, 1'b1};
    m_busy = 0; m_good = 0; m_valid = 0; m_fe = 0; m_ov = 0;
    m_t0 = 0; m_good_at = 0; m_word = '0; m_dat = '0;
  endtask

  // Advance the model by one edge using the inputs that were stable before it.
  task automatic model_step();
    bit s;
    int rel, k;
    if (!i_sclr_n) begin
      model_reset();
      return;
    end
    s = line_q.pop_front();
    line_q.push_back(i_dat);
    m_fe = 0;
    m_ov = 0;
    if (m_good && cyc == m_good_at) begin
      m_good = 0;
      if (!m_valid || i_ready) begin
        m_dat   = m_word;
        m_valid = 1;
      end else begin
        m_ov = 1;
      end
    end else if (m_valid && i_ready) begin
      m_valid = 0;
    end
    if (!m_busy) begin
      if (!s) begin
        m_busy = 1;
        m_t0   = cyc;
      end
    end else begin
      rel = cyc - m_t0 - DIV / 2;
      if (rel == 0) begin
        if (s) m_busy = 0;
      end else if (rel > 0 && rel % DIV == 0) begin
        k = rel / DIV - 1;
        if (k < BIT_SIZE) begin
          m_word[k] = s;
        end else begin
          m_busy = 0;
          if (s) begin
            m_good    = 1;
            m_good_at = cyc + 1;
          end else begin
            m_fe = 1;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    chk("valid", o_valid, m_valid);
    chk("dat", o_dat, m_dat);
    chk("busy", o_busy, m_busy);
    chk("frame_err", o_frame_err, m_fe);
    chk("overrun", o_overrun, m_ov);
    if (o_busy) cnt_busy++;
    if (o_frame_err) cnt_fe++;
    if (o_overrun) cnt_ov++;
    if (o_valid) cnt_vcyc++;
    if (o_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = o_valid;
  endtask

  task automatic drive_ready(input int mode);
    if (mode == 2) i_ready = ($urandom_range(0, 3) == 0);
    else           i_ready = (mode == 1);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input int rdy_mode,
                            input int rdy_at, input int gap, input int nbits);
    logic [9:0] line;
    int j;
    line = {stop, d, 1'b0};
    for (int b = 0; b < nbits; b++) begin
      for (int t = 0; t < DIV; t++) begin
        j = b * DIV + t;
        i_dat = line[b];
        drive_ready(rdy_mode);
        if (j == rdy_at) i_ready = 1'b1;
        if (j == 0) frame_m = cyc + 1;
        tick();
      end
    end
    for (int t = 0; t < gap * DIV; t++) begin
      i_dat = 1'b1;
      drive_ready(rdy_mode);
      tick();
    end
    i_dat   = 1'b1;
    i_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, ov0, v0, b0;
    vecs[0] = '{8'hA5, 1'b1, 0, -1,     1, 1'b1, 8'hA5, 1'b1, 0, 0};
    vecs[1] = '{8'h3C, 1'b0, 0, -1,     1, 1'b0, 8'hA5, 1'b0, 1, 0};
    vecs[2] = '{8'h81, 1'b1, 0, -1,     1, 1'b1, 8'h81, 1'b1, 0, 0};
    vecs[3] = '{8'h11, 1'b1, 0, -1,     0, 1'b0, 8'h11, 1'b1, 0, 0};
    vecs[4] = '{8'h22, 1'b1, 0, -1,     1, 1'b1, 8'h11, 1'b1, 0, 1};
    vecs[5] = '{8'h11, 1'b1, 0, -1,     0, 1'b0, 8'h11, 1'b1, 0, 0};
    vecs[6] = '{8'h22, 1'b1, 0, J_LOAD, 1, 1'b1, 8'h22, 1'b1, 0, 0};
    vecs[7] = '{8'h00, 1'b1, 1, -1,     1, 1'b0, 8'h00, 1'b0, 0, 0};
    vecs[8] = '{8'hFF, 1'b1, 1, -1,     1, 1'b0, 8'hFF, 1'b0, 0, 0};
    vecs[9] = '{8'h55, 1'b1, 1, -1,     1, 1'b0, 8'h55, 1'b0, 0, 0};

    i_sclr_n = 1'b0;
    i_dat    = 1'b1;
    i_ready  = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_dat", o_dat, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_frame_err", o_frame_err, 0);
    chk("rst_overrun", o_overrun, 0);
    repeat (2) tick();
    i_sclr_n = 1'b1;
    repeat (4) tick();

    for (int i = 0; i < 10; i++) begin
      fe0 = cnt_fe; ov0 = cnt_ov; v0 = cnt_vcyc;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].rdy_mode, vecs[i].rdy_at, vecs[i].gap, 10);
      chk($sformatf("row%0d_dat", i), o_dat, vecs[i].exp_dat);
      chk($sformatf("row%0d_valid", i), o_valid, vecs[i].exp_valid);
      chk($sformatf("row%0d_fe_pulses", i), cnt_fe - fe0, vecs[i].exp_fe);
      chk($sformatf("row%0d_ov_pulses", i), cnt_ov - ov0, vecs[i].exp_ov);
      if (vecs[i].rdy_mode == 1) chk($sformatf("row%0d_valid_cycles", i), cnt_vcyc - v0, 1);
      if (i == 0) chk("latency_t0_to_valid", rise_cyc - (frame_m + 2), LAT);
      if (vecs[i].pop) begin
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk($sformatf("row%0d_pop_valid", i), o_valid, 0);
      end
    end

    // Two-cycle low glitch on the line: START for DIV/2 cycles, then back to IDLE.
    fe0 = cnt_fe; ov0 = cnt_ov; v0 = cnt_vcyc; b0 = cnt_busy;
    i_dat = 1'b0;
    repeat (2) tick();
    i_dat = 1'b1;
    repeat (3 * DIV) tick();
    chk("glitch_busy_cycles", cnt_busy - b0, DIV / 2);
    chk("glitch_fe", cnt_fe - fe0, 0);
    chk("glitch_ov", cnt_ov - ov0, 0);
    chk("glitch_valid", cnt_vcyc - v0, 0);

    // Asynchronous reset in the middle of data bit 4.
    send_frame(8'h5A, 1'b1, 0, -1, 0, 5);
    i_dat = 1'b1;
    repeat (3) tick();
    chk("prerst_busy", o_busy, 1);
    #2;
    i_sclr_n = 1'b0;
    #1;
    chk("midrst_busy", o_busy, 0);
    chk("midrst_valid", o_valid, 0);
    chk("midrst_dat", o_dat, 0);
    chk("midrst_frame_err", o_frame_err, 0);
    chk("midrst_overrun", o_overrun, 0);
    repeat (3) tick();
    i_sclr_n = 1'b1;
    repeat (4) tick();
    fe0 = cnt_fe; ov0 = cnt_ov;
    send_frame(8'h5A, 1'b1, 0, -1, 1, 10);
    chk("postrst_dat", o_dat, 8'h5A);
    chk("postrst_valid", o_valid, 1);
    chk("postrst_fe", cnt_fe - fe0, 0);
    chk("postrst_ov", cnt_ov - ov0, 0);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;

    // Random traffic: random words, occasional bad stop bits and glitches, random i_ready.
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        i_dat = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        i_dat = 1'b1;
        repeat (DIV) tick();
      end
      send_frame(8'($urandom), ($urandom_range(0, 4) != 0), 2, -1, $urandom_range(0, 2), 10);
    end
    i_dat = 1'b1;
    repeat (2 * DIV) begin
      drive_ready(2);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
